bit_stream_sequencer: RTL
=========================

BIT_STREAM_SEQUENCER -- requirements
Module: bit_stream_sequencer

Interface
REQ-001 The block SHALL have one parameter: BURST_WORDS, default 4, number of 16-bit words per frame (legal range 1..255).
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset, with ports as follows:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- word_valid  in  1  upstream word offered
- word_in  in  16  keystream/data word
- word_ready  out  1  block can accept a word
- bit_ready  in  1  downstream accepts current bit
- abort  in  1  synchronous frame abort
- bit_out  out  1  serial bit, MSB first
- bit_valid  out  1  bit_out is valid
- bit_last  out  1  current bit is the final bit of the frame
- sel_count  out  4  bit index driven to the bit-selector clock input
- sel_lock  out  1  bit-selector lock control
- frame_done  out  1  one-cycle pulse after the frame's final bit transfers
- busy  out  1  frame in progress

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, STREAM and GAP.
REQ-004 In IDLE, word_ready SHALL be 1, bit_valid SHALL be 0 and sel_lock SHALL be 1.
REQ-005 In IDLE, when word_valid=1 the block SHALL capture word_in into a 16-bit holding register, clear sel_count to 0, and go to STREAM on the next edge.
REQ-006 In STREAM, bit_valid SHALL be 1, sel_lock SHALL be 0, and bit_out SHALL equal word_reg[15 - sel_count].
- Reversed mapping: count 0 selects bit 15; count 15 selects bit 0.
REQ-007 A bit transfer SHALL occur only on a cycle with bit_valid=1 and bit_ready=1.
- With bit_ready=0, sel_count, bit_out and word_reg SHALL hold.
REQ-008 On a transfer with sel_count<15, sel_count SHALL increment by 1.
REQ-009 On a transfer with sel_count=15, sel_count SHALL wrap to 0 and the words-sent counter (8-bit) SHALL increment.
- If the incremented counter equals BURST_WORDS: go to IDLE, clear the words-sent counter, pulse frame_done on the following cycle.
- Otherwise: go to GAP.
REQ-010 GAP SHALL behave as IDLE for word acceptance (word_ready=1, bit_valid=0, sel_lock=1) but SHALL keep busy=1.
- word_valid=1 in GAP SHALL load the next word and go to STREAM.
REQ-011 word_ready SHALL be 0 in STREAM, giving a minimum one-cycle bubble between words.
REQ-012 bit_last SHALL be 1 only in STREAM with sel_count=15 and words-sent = BURST_WORDS-1.
REQ-013 busy SHALL be 1 from the cycle after the first word of a frame is accepted until the cycle after the final bit transfers.
REQ-014 abort=1 SHALL, at the next edge from any state, force IDLE, clear sel_count and the words-sent counter, and suppress frame_done.
- abort SHALL take priority over word acceptance and bit transfer in the same cycle.
REQ-015 A simultaneous word_valid and abort in IDLE or GAP SHALL NOT load the word.
REQ-016 frame_done SHALL be registered and SHALL never be high for two consecutive cycles.
REQ-017 All outputs SHALL be driven from registers or from state-only decode, with no combinational path from bit_ready to any output.

Reset
REQ-018 While reset=1, the block SHALL asynchronously set:
- state = IDLE
- sel_count = 0, sel_lock = 1
- word_reg = 0, words-sent = 0
- bit_out = 0, bit_valid = 0, bit_last = 0
- frame_done = 0, busy = 0
- word_ready SHALL be 0 while reset is asserted.
REQ-019 Reset asserted mid-frame SHALL discard the frame with no frame_done; after deassertion the block SHALL be in IDLE with word_ready=1.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- BURST_WORDS=1, word 0xACF0, bit_ready held 1 -> bits 1,0,1,0,1,1,0,0,1,1,1,1,0,0,0,0 on 16 consecutive cycles; bit_last on the 16th; frame_done one cycle later.
- BURST_WORDS=4, bit_ready=1, words 0x530F, 0xFFFF, 0x0000, 0x8001 -> 64 bits in order; one GAP bubble between words; busy high throughout; exactly one frame_done.
- Backpressure: bit_ready toggled 1,0,0,1 during word 0xACF0 -> sel_count and bit_out hold on the 0 cycles; total 16 transfers.
- abort at sel_count=7 of word 2 -> IDLE next edge; no frame_done; next frame starts at sel_count=0 with words-sent=0.
- Async reset pulse mid-STREAM (not clock-aligned) -> all outputs go to reset values immediately; sel_lock=1.
- word_valid and abort together in GAP -> word not loaded; state IDLE.

Source files
------------

// File: rtl/bit_stream_sequencer.sv
// Serialises BURST_WORDS 16-bit words per frame, MSB first, with ready/valid
// handshakes on both sides and a one-cycle GAP bubble between words.
module bit_stream_sequencer #(
    parameter int BURST_WORDS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        word_valid,
    input  logic [15:0] word_in,
    output logic        word_ready,
    input  logic        bit_ready,
    input  logic        abort,
    output logic        bit_out,
    output logic        bit_valid,
    output logic        bit_last,
    output logic [3:0]  sel_count,
    output logic        sel_lock,
    output logic        frame_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } state_t;

    localparam logic [7:0] BURST_W    = 8'(BURST_WORDS);
    localparam logic [7:0] BURST_LAST = BURST_W - 8'd1;

    state_t      state_r, state_next_s;
    logic [3:0]  count_r, count_next_s;
    logic [7:0]  words_r, words_next_s;
    logic [15:0] word_r, word_next_s;
    logic        done_next_s;
    logic        bit_out_r;
    logic        bit_last_r;
    logic        frame_done_r;

    // Next-state, counters and holding-register update; abort overrides all.
    always_comb begin
        state_next_s = state_r;
        count_next_s = count_r;
        words_next_s = words_r;
        word_next_s  = word_r;
        done_next_s  = 1'b0;
        case (state_r)
            IDLE, GAP: begin
                if (word_valid) begin
                    word_next_s  = word_in;
                    count_next_s = 4'd0;
                    state_next_s = STREAM;
                end else begin
                    state_next_s = state_r;
                end
            end
            STREAM: begin
                if (bit_ready) begin
                    if (count_r == 4'd15) begin
                        count_next_s = 4'd0;
                        if ((words_r + 8'd1) == BURST_W) begin
                            words_next_s = 8'd0;
                            state_next_s = IDLE;
                            done_next_s  = 1'b1;
                        end else begin
                            words_next_s = words_r + 8'd1;
                            state_next_s = GAP;
                        end
                    end else begin
                        count_next_s = count_r + 4'd1;
                    end
                end else begin
                    count_next_s = count_r;
                end
            end
            default: begin
                state_next_s = IDLE;
                count_next_s = 4'd0;
                words_next_s = 8'd0;
            end
        endcase
        if (abort) begin
            state_next_s = IDLE;
            count_next_s = 4'd0;
            words_next_s = 8'd0;
            word_next_s  = word_r;
            done_next_s  = 1'b0;
        end else begin
            done_next_s  = done_next_s;
        end
    end

    // State and datapath registers; bit_out/bit_last are precomputed from next values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            count_r      <= 4'd0;
            words_r      <= 8'd0;
            word_r       <= 16'd0;
            bit_out_r    <= 1'b0;
            bit_last_r   <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            count_r      <= count_next_s;
            words_r      <= words_next_s;
            word_r       <= word_next_s;
            bit_out_r    <= word_next_s[4'd15 - count_next_s];
            bit_last_r   <= (state_next_s == STREAM) && (count_next_s == 4'd15) &&
                            (words_next_s == BURST_LAST);
            frame_done_r <= done_next_s;
        end
    end

    // word_ready is also masked by reset so it reads 0 while reset is held.
    assign word_ready = (state_r != STREAM) & ~reset;
    assign bit_valid  = (state_r == STREAM);
    assign sel_lock   = (state_r != STREAM);
    assign busy       = (state_r != IDLE);
    assign sel_count  = count_r;
    assign bit_out    = bit_out_r;
    assign bit_last   = bit_last_r;
    assign frame_done = frame_done_r;

endmodule
